spi_ram_arbiter: RTL and testbench

- Shares the single-port SDRAM controller between three users: the SPI flash emulator (read-only, latency-critical), a host port (USB/serial loader doing byte reads and writes), and periodic refresh.
- Honours the flash block's critical lock. While the lock is held, host accesses and refreshes are held off. Refreshes owed during the lock are repaid once it drops.

---
 rtl/spispy_pkg.sv | 20 ++
 rtl/spi_ram_arbiter_if.sv | 52 +++++
 rtl/refresh_scheduler.sv | 50 +++++
 rtl/spi_ram_arbiter.sv | 159 +++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spispy_pkg.sv
// Shared definitions for the SPI-flash-emulator RAM arbiter.
//   arb_state_t                : arbiter FSM states
//   OWED_W                     : width of the owed-refresh counter
//   REFRESH_INTERVAL_DEFAULT   : clk cycles between refresh debits
//   REFRESH_MAX_OWED_DEFAULT   : saturation limit of the owed counter
package spispy_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FLASH   = 3'd1,
        HOST_RD = 3'd2,
        HOST_WR = 3'd3,
        REFRESH = 3'd4
    } arb_state_t;

    localparam int OWED_W                   = 4;
    localparam int REFRESH_INTERVAL_DEFAULT = 780;
    localparam int REFRESH_MAX_OWED_DEFAULT = 15;

endpackage

// File: rtl/spi_ram_arbiter_if.sv
// Bus bundle between the arbiter and its three users plus the SDRAM controller.
//   slave  : arbiter view (flash/host/controller responses in, requests out)
//   master : environment view (flash block, host port, controller)
interface spi_ram_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              flash_critical;
    logic [ADDR_W-1:0] flash_addr;
    logic              flash_read_enable;
    logic [7:0]        flash_read_data;
    logic              flash_read_valid;

    logic [ADDR_W-1:0] host_addr;
    logic [7:0]        host_wdata;
    logic              host_rd_strobe;
    logic              host_wr_strobe;
    logic              host_busy;
    logic [7:0]        host_rdata;
    logic              host_done;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_read_enable;
    logic              ram_write_enable;
    logic [7:0]        ram_write_data;
    logic [7:0]        ram_read_data;
    logic              ram_read_valid;
    logic              ram_write_done;
    logic              ram_refresh;
    logic              ram_refresh_done;
    logic              refresh_overflow;

    modport slave (
        input  flash_critical, flash_addr, flash_read_enable,
        input  host_addr, host_wdata, host_rd_strobe, host_wr_strobe,
        input  ram_read_data, ram_read_valid, ram_write_done, ram_refresh_done,
        output flash_read_data, flash_read_valid,
        output host_busy, host_rdata, host_done,
        output ram_addr, ram_read_enable, ram_write_enable, ram_write_data,
        output ram_refresh, refresh_overflow
    );

    modport master (
        output flash_critical, flash_addr, flash_read_enable,
        output host_addr, host_wdata, host_rd_strobe, host_wr_strobe,
        output ram_read_data, ram_read_valid, ram_write_done, ram_refresh_done,
        input  flash_read_data, flash_read_valid,
        input  host_busy, host_rdata, host_done,
        input  ram_addr, ram_read_enable, ram_write_enable, ram_write_data,
        input  ram_refresh, refresh_overflow
    );

endinterface

// File: rtl/refresh_scheduler.sv
// Refresh bookkeeping: free-running interval timer, owed-refresh counter and
// sticky overflow flag.
//   clk, reset       : clock, synchronous active-high reset
//   tick_dec         : one refresh has just completed
//   owed_nonzero     : at least one refresh is owed
//   refresh_overflow : sticky, a debit was lost because the counter was full
module refresh_scheduler
    import spispy_pkg::*;
#(
    parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEFAULT,
    parameter int REFRESH_MAX_OWED = REFRESH_MAX_OWED_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_dec,
    output logic owed_nonzero,
    output logic refresh_overflow
);

    localparam int CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);
    localparam logic [OWED_W-1:0] OWED_MAX = OWED_W'(REFRESH_MAX_OWED);

    logic [CNT_W-1:0]  interval_cnt;
    logic [OWED_W-1:0] owed;
    logic              wrap;

    assign wrap         = (interval_cnt == CNT_LAST);
    assign owed_nonzero = (owed != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            interval_cnt     <= '0;
            owed             <= '0;
            refresh_overflow <= 1'b0;
        end else begin
            interval_cnt <= wrap ? '0 : interval_cnt + 1'b1;
            // A debit and a repayment in the same cycle cancel out.
            if (wrap && !tick_dec) begin
                if (owed == OWED_MAX)
                    refresh_overflow <= 1'b1;
                else
                    owed <= owed + 1'b1;
            end else if (tick_dec && !wrap && owed_nonzero) begin
                owed <= owed - 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Arbitrates the single-port SDRAM controller between the SPI flash emulator
// (latency critical, read only), the host loader port and periodic refresh.
// flash_critical holds off host and refresh; owed refreshes are repaid after.
//   clk, reset : clock, synchronous active-high reset
//   bus        : flash / host / controller signals (spi_ram_arbiter_if.slave)
//
// state   | meaning
// IDLE    | no controller request; priority decision each cycle
// FLASH   | flash read in flight, ram_read_enable held until ram_read_valid
// HOST_RD | host read in flight, ram_read_enable held until ram_read_valid
// HOST_WR | host write in flight, ram_write_enable held until ram_write_done
// REFRESH | ram_refresh held until ram_refresh_done
module spi_ram_arbiter
    import spispy_pkg::*;
#(
    parameter int ADDR_W           = 32,
    parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEFAULT,
    parameter int REFRESH_MAX_OWED = REFRESH_MAX_OWED_DEFAULT
) (
    input logic              clk,
    input logic              reset,
    spi_ram_arbiter_if.slave bus
);

    arb_state_t        state, state_next;

    logic              host_pending;
    logic              host_is_wr;
    logic [ADDR_W-1:0] host_addr_q;
    logic [7:0]        host_wdata_q;
    logic              host_complete;

    logic [ADDR_W-1:0] ram_addr_q;
    logic              ram_read_enable_q;
    logic              ram_write_enable_q;
    logic [7:0]        ram_write_data_q;
    logic              ram_refresh_q;
    logic [7:0]        host_rdata_q;
    logic              host_done_q;

    logic              tick_dec;
    logic              owed_nonzero;

    refresh_scheduler #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL),
        .REFRESH_MAX_OWED (REFRESH_MAX_OWED)
    ) u_refresh_scheduler (
        .clk              (clk),
        .reset            (reset),
        .tick_dec         (tick_dec),
        .owed_nonzero     (owed_nonzero),
        .refresh_overflow (bus.refresh_overflow)
    );

    always_comb begin
        state_next    = state;
        tick_dec      = 1'b0;
        host_complete = 1'b0;
        case (state)
            IDLE: begin
                if (bus.flash_read_enable)
                    state_next = FLASH;
                else if (owed_nonzero && !bus.flash_critical)
                    state_next = REFRESH;
                else if (host_pending && !bus.flash_critical)
                    state_next = host_is_wr ? HOST_WR : HOST_RD;
            end
            FLASH: begin
                if (bus.ram_read_valid)
                    state_next = IDLE;
            end
            HOST_RD: begin
                if (bus.ram_read_valid) begin
                    state_next    = IDLE;
                    host_complete = 1'b1;
                end
            end
            HOST_WR: begin
                if (bus.ram_write_done) begin
                    state_next    = IDLE;
                    host_complete = 1'b1;
                end
            end
            REFRESH: begin
                if (bus.ram_refresh_done) begin
                    state_next = IDLE;
                    tick_dec   = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Controller requests are registered from the next state, so they are
    // mutually exclusive by construction and rise on the grant edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr_q         <= '0;
            ram_read_enable_q  <= 1'b0;
            ram_write_enable_q <= 1'b0;
            ram_write_data_q   <= '0;
            ram_refresh_q      <= 1'b0;
            host_rdata_q       <= '0;
            host_done_q        <= 1'b0;
            host_pending       <= 1'b0;
            host_is_wr         <= 1'b0;
            host_addr_q        <= '0;
            host_wdata_q       <= '0;
        end else begin
            ram_read_enable_q  <= (state_next == FLASH) || (state_next == HOST_RD);
            ram_write_enable_q <= (state_next == HOST_WR);
            ram_refresh_q      <= (state_next == REFRESH);

            if (state == IDLE) begin
                if (state_next == FLASH)
                    ram_addr_q <= bus.flash_addr;
                else if (state_next == HOST_RD)
                    ram_addr_q <= host_addr_q;
                else if (state_next == HOST_WR) begin
                    ram_addr_q       <= host_addr_q;
                    ram_write_data_q <= host_wdata_q;
                end
            end

            host_done_q <= host_complete;
            if (state == HOST_RD && bus.ram_read_valid)
                host_rdata_q <= bus.ram_read_data;

            // Strobes are only looked at while no host op is outstanding.
            if (host_complete) begin
                host_pending <= 1'b0;
            end else if (!host_pending && (bus.host_wr_strobe || bus.host_rd_strobe)) begin
                host_pending <= 1'b1;
                host_is_wr   <= bus.host_wr_strobe;
                host_addr_q  <= bus.host_addr;
                host_wdata_q <= bus.host_wdata;
            end
        end
    end

    assign bus.ram_addr         = ram_addr_q;
    assign bus.ram_read_enable  = ram_read_enable_q;
    assign bus.ram_write_enable = ram_write_enable_q;
    assign bus.ram_write_data   = ram_write_data_q;
    assign bus.ram_refresh      = ram_refresh_q;
    assign bus.host_rdata       = host_rdata_q;
    assign bus.host_done        = host_done_q;
    assign bus.host_busy        = host_pending;
    assign bus.flash_read_data  = bus.ram_read_data;
    assign bus.flash_read_valid = bus.ram_read_valid && (state == FLASH);

endmodule

// File: tb/tb_spi_ram_arbiter.sv
module tb_spi_ram_arbiter;

    localparam int RI = 780;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   lat_cfg;
    int   lat_cnt;
    logic resp_sent;
    logic [7:0] mem [0:4095];

    spi_ram_arbiter_if #(.ADDR_W(32)) bus ();

    spi_ram_arbiter #(
        .ADDR_W           (32),
        .REFRESH_INTERVAL (RI),
        .REFRESH_MAX_OWED (15)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SDRAM controller model: answers each request lat_cfg cycles after it rises.
    always @(posedge clk) begin
        bus.ram_read_valid   <= 1'b0;
        bus.ram_write_done   <= 1'b0;
        bus.ram_refresh_done <= 1'b0;
        bus.ram_read_data    <= 8'h00;
        if (reset) begin
            lat_cnt          <= 0;
            resp_sent        <= 1'b0;
            mem[12'h345]     <= 8'hA5;
            mem[12'h346]     <= 8'h3C;
        end else if (bus.ram_read_enable || bus.ram_write_enable || bus.ram_refresh) begin
            if (!resp_sent) begin
                if (lat_cnt >= lat_cfg - 1) begin
                    resp_sent <= 1'b1;
                    lat_cnt   <= 0;
                    if (bus.ram_read_enable) begin
                        bus.ram_read_valid <= 1'b1;
                        bus.ram_read_data  <= mem[bus.ram_addr[11:0]];
                    end else if (bus.ram_write_enable) begin
                        bus.ram_write_done <= 1'b1;
                        mem[bus.ram_addr[11:0]] <= bus.ram_write_data;
                    end else begin
                        bus.ram_refresh_done <= 1'b1;
                    end
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end
        end else begin
            resp_sent <= 1'b0;
            lat_cnt   <= 0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ((int'(bus.ram_read_enable) + int'(bus.ram_write_enable) + int'(bus.ram_refresh)) > 1) begin
                errors++;
                $display("FAIL req_mutex rd=%b wr=%b rf=%b at %0t", bus.ram_read_enable,
                         bus.ram_write_enable, bus.ram_refresh, $time);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset                 = 1'b1;
        lat_cfg               = 3;
        bus.flash_critical    = 1'b0;
        bus.flash_addr        = '0;
        bus.flash_read_enable = 1'b0;
        bus.host_addr         = '0;
        bus.host_wdata        = '0;
        bus.host_rd_strobe    = 1'b0;
        bus.host_wr_strobe    = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [63:0] out_vec();
        return {bus.ram_addr, bus.ram_read_enable, bus.ram_write_enable, bus.ram_write_data,
                bus.ram_refresh, bus.host_rdata, bus.host_done, bus.host_busy,
                bus.refresh_overflow, bus.flash_read_valid, bus.flash_read_data};
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if (out_vec() !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", out_vec());
        end
    endtask

    task automatic test_flash_read();
        int n;
        do_reset();
        bus.flash_addr        = 32'h0001_2345;
        bus.flash_read_enable = 1'b1;
        checks++;
        if (bus.ram_read_enable !== 1'b0) begin errors++; $display("FAIL flash_req_early got %b want 0", bus.ram_read_enable); end
        tick();
        checks++;
        if (bus.ram_read_enable !== 1'b1) begin errors++; $display("FAIL flash_req_latency got %b want 1", bus.ram_read_enable); end
        checks++;
        if (bus.ram_addr !== 32'h0001_2345) begin errors++; $display("FAIL flash_addr got %h want 00012345", bus.ram_addr); end
        n = 0;
        while (!bus.flash_read_valid && n < 10) begin tick(); n++; end
        checks++;
        if (n !== 3) begin errors++; $display("FAIL flash_valid_latency got %0d want 3", n); end
        checks++;
        if (bus.flash_read_data !== 8'hA5) begin errors++; $display("FAIL flash_data got %h want a5", bus.flash_read_data); end
        bus.flash_read_enable = 1'b0;
        tick();
        checks++;
        if (bus.ram_read_enable !== 1'b0) begin errors++; $display("FAIL flash_drop got %b want 0", bus.ram_read_enable); end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset();
        bus.flash_addr        = 32'h0000_0345;
        bus.flash_read_enable = 1'b1;
        n = 0;
        while (!bus.flash_read_valid && n < 10) begin tick(); n++; end
        bus.flash_read_enable = 1'b0;
        tick();
        bus.flash_addr        = 32'h0000_0346;
        bus.flash_read_enable = 1'b1;
        tick();
        checks++;
        if (bus.ram_read_enable !== 1'b1 || bus.ram_addr !== 32'h0000_0346) begin
            errors++;
            $display("FAIL b2b_rerequest got rd=%b addr=%h want rd=1 addr=00000346", bus.ram_read_enable, bus.ram_addr);
        end
        n = 0;
        while (!bus.flash_read_valid && n < 10) begin tick(); n++; end
        checks++;
        if (bus.flash_read_data !== 8'h3C || n !== 3) begin
            errors++;
            $display("FAIL b2b_data got %h after %0d want 3c after 3", bus.flash_read_data, n);
        end
        bus.flash_read_enable = 1'b0;
    endtask

    task automatic test_host_write_read();
        int n;
        int dones;
        int busy_gaps;
        logic wr_seen;
        logic flash_leak;
        do_reset();
        dones = 0; busy_gaps = 0; wr_seen = 1'b0; flash_leak = 1'b0;
        bus.host_addr      = 32'h0000_0100;
        bus.host_wdata     = 8'h5A;
        bus.host_wr_strobe = 1'b1;
        checks++;
        if (bus.host_busy !== 1'b0) begin errors++; $display("FAIL host_busy_early got %b want 0", bus.host_busy); end
        tick();
        bus.host_wr_strobe = 1'b0;
        n = 0;
        while (!bus.host_done && n < 20) begin
            if (bus.host_busy !== 1'b1) busy_gaps++;
            if (bus.ram_write_enable && !wr_seen) begin
                wr_seen = 1'b1;
                checks++;
                if (bus.ram_addr !== 32'h100 || bus.ram_write_data !== 8'h5A) begin
                    errors++;
                    $display("FAIL host_wr_bus got addr=%h data=%h want 00000100/5a", bus.ram_addr, bus.ram_write_data);
                end
            end
            tick(); n++;
        end
        if (bus.host_done) dones++;
        checks++;
        if (bus.host_busy !== 1'b0 || busy_gaps !== 0) begin
            errors++;
            $display("FAIL host_wr_busy got busy=%b gaps=%0d want 0/0", bus.host_busy, busy_gaps);
        end
        tick();
        bus.host_rd_strobe = 1'b1;
        tick();
        bus.host_rd_strobe = 1'b0;
        n = 0;
        while (!bus.host_done && n < 20) begin
            if (bus.host_busy !== 1'b1) busy_gaps++;
            if (bus.flash_read_valid) flash_leak = 1'b1;
            tick(); n++;
        end
        if (bus.host_done) dones++;
        checks++;
        if (dones !== 2) begin errors++; $display("FAIL host_done_count got %0d want 2", dones); end
        checks++;
        if (bus.host_rdata !== 8'h5A) begin errors++; $display("FAIL host_rdata got %h want 5a", bus.host_rdata); end
        checks++;
        if (busy_gaps !== 0 || flash_leak !== 1'b0) begin
            errors++;
            $display("FAIL host_rd_busy got gaps=%0d flash_valid=%b want 0/0", busy_gaps, flash_leak);
        end
        tick();
        checks++;
        if (bus.host_done !== 1'b0) begin errors++; $display("FAIL host_done_pulse got %b want 0", bus.host_done); end
    endtask

    task automatic test_strobe_rules();
        int n;
        int dones;
        logic rd_seen;
        do_reset();
        rd_seen = 1'b0; dones = 0;
        bus.host_addr      = 32'h0000_0200;
        bus.host_wdata     = 8'h77;
        bus.host_wr_strobe = 1'b1;
        bus.host_rd_strobe = 1'b1;
        tick();
        bus.host_wr_strobe = 1'b0;
        bus.host_rd_strobe = 1'b0;
        tick();
        // Strobe while busy must be dropped.
        bus.host_addr      = 32'h0000_0202;
        bus.host_rd_strobe = 1'b1;
        tick();
        bus.host_rd_strobe = 1'b0;
        n = 0;
        while (n < 30) begin
            if (bus.ram_read_enable) rd_seen = 1'b1;
            if (bus.host_done) dones++;
            tick(); n++;
        end
        checks++;
        if (rd_seen !== 1'b0 || dones !== 1) begin
            errors++;
            $display("FAIL strobe_rules got rd_seen=%b dones=%0d want 0/1", rd_seen, dones);
        end
        bus.host_addr      = 32'h0000_0200;
        bus.host_rd_strobe = 1'b1;
        tick();
        bus.host_rd_strobe = 1'b0;
        n = 0;
        while (!bus.host_done && n < 20) begin tick(); n++; end
        checks++;
        if (bus.host_rdata !== 8'h77) begin errors++; $display("FAIL write_wins got %h want 77", bus.host_rdata); end
    endtask

    task automatic test_critical_refresh();
        int   refs;
        int   n;
        logic prev;
        do_reset();
        bus.flash_critical = 1'b1;
        refs = 0;
        for (int i = 0; i < 5 * RI + 5; i++) begin
            tick();
            if (bus.ram_refresh) refs++;
        end
        checks++;
        if (refs !== 0) begin errors++; $display("FAIL crit_no_refresh got %0d want 0", refs); end
        bus.host_addr      = 32'h0000_0100;
        bus.host_rd_strobe = 1'b1;
        tick();
        bus.host_rd_strobe = 1'b0;
        tick();
        checks++;
        if (bus.host_busy !== 1'b1 || bus.ram_read_enable !== 1'b0) begin
            errors++;
            $display("FAIL crit_host_held got busy=%b rd=%b want 1/0", bus.host_busy, bus.ram_read_enable);
        end
        bus.flash_critical = 1'b0;
        refs = 0; prev = 1'b0; n = 0;
        while (!bus.ram_read_enable && n < 200) begin
            tick(); n++;
            if (bus.ram_refresh && !prev) refs++;
            prev = bus.ram_refresh;
        end
        checks++;
        if (refs !== 5) begin errors++; $display("FAIL crit_repay got %0d refreshes want 5", refs); end
        n = 0;
        while (!bus.host_done && n < 20) begin tick(); n++; end
        checks++;
        if (bus.host_done !== 1'b1 || bus.refresh_overflow !== 1'b0) begin
            errors++;
            $display("FAIL crit_host_done got done=%b ovf=%b want 1/0", bus.host_done, bus.refresh_overflow);
        end
    endtask

    task automatic test_host_vs_flash();
        int   n;
        logic aborted;
        logic rf_seen;
        do_reset();
        lat_cfg = 20;
        aborted = 1'b0;
        rf_seen = 1'b0;
        for (int i = 0; i < RI - 15; i++) tick();
        bus.host_addr      = 32'h0000_0300;
        bus.host_wdata     = 8'h42;
        bus.host_wr_strobe = 1'b1;
        tick();
        bus.host_wr_strobe = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.flash_critical    = 1'b1;
        bus.flash_addr        = 32'h0000_0345;
        bus.flash_read_enable = 1'b1;
        n = 0;
        while (n < 60) begin
            tick(); n++;
            if (bus.host_done) break;
            if (!bus.ram_write_enable) aborted = 1'b1;
        end
        checks++;
        if (bus.host_done !== 1'b1 || aborted !== 1'b0) begin
            errors++;
            $display("FAIL hvf_write_complete got done=%b aborted=%b want 1/0", bus.host_done, aborted);
        end
        lat_cfg = 3;
        tick();
        checks++;
        if (bus.ram_read_enable !== 1'b1 || bus.ram_refresh !== 1'b0 || bus.ram_addr !== 32'h345) begin
            errors++;
            $display("FAIL hvf_flash_first got rd=%b rf=%b addr=%h want 1/0/00000345",
                     bus.ram_read_enable, bus.ram_refresh, bus.ram_addr);
        end
        n = 0;
        while (!bus.flash_read_valid && n < 10) begin tick(); n++; end
        bus.flash_read_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.ram_refresh) rf_seen = 1'b1;
        end
        checks++;
        if (rf_seen !== 1'b0) begin errors++; $display("FAIL hvf_refresh_held got %b want 0", rf_seen); end
        bus.flash_critical = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.ram_refresh) rf_seen = 1'b1;
        end
        checks++;
        if (rf_seen !== 1'b1) begin errors++; $display("FAIL hvf_refresh_owed got %b want 1", rf_seen); end
    endtask

    task automatic test_overflow();
        int   refs;
        logic prev;
        do_reset();
        bus.flash_critical = 1'b1;
        for (int i = 0; i < 15 * RI + 5; i++) tick();
        checks++;
        if (bus.refresh_overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_15 got %b want 0", bus.refresh_overflow); end
        for (int i = 0; i < 2 * RI; i++) tick();
        checks++;
        if (bus.refresh_overflow !== 1'b1) begin errors++; $display("FAIL ovf_at_17 got %b want 1", bus.refresh_overflow); end
        bus.flash_critical = 1'b0;
        refs = 0; prev = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (bus.ram_refresh && !prev) refs++;
            prev = bus.ram_refresh;
        end
        checks++;
        if (refs !== 15 || bus.refresh_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_repay got %0d refreshes ovf=%b want 15/1", refs, bus.refresh_overflow);
        end
        do_reset();
        checks++;
        if (bus.refresh_overflow !== 1'b0) begin errors++; $display("FAIL ovf_reset got %b want 0", bus.refresh_overflow); end
    endtask

    task automatic test_reset_mid_read();
        int   n;
        logic late_done;
        do_reset();
        lat_cfg            = 20;
        late_done          = 1'b0;
        bus.host_addr      = 32'h0000_0100;
        bus.host_rd_strobe = 1'b1;
        tick();
        bus.host_rd_strobe = 1'b0;
        n = 0;
        while (!bus.ram_read_enable && n < 10) begin tick(); n++; end
        checks++;
        if (bus.ram_read_enable !== 1'b1) begin errors++; $display("FAIL rst_mid_start got %b want 1", bus.ram_read_enable); end
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if (out_vec() !== 64'h0) begin errors++; $display("FAIL rst_mid_outputs got %h want 0", out_vec()); end
        reset   = 1'b0;
        lat_cfg = 3;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (bus.host_done || bus.host_busy || bus.ram_read_enable) late_done = 1'b1;
        end
        checks++;
        if (late_done !== 1'b0) begin errors++; $display("FAIL rst_mid_abandon got %b want 0", late_done); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        lat_cfg = 3;
        test_reset();
        test_flash_read();
        test_back_to_back();
        test_host_write_read();
        test_strobe_rules();
        test_critical_refresh();
        test_host_vs_flash();
        test_overflow();
        test_reset_mid_read();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
